camera_frame_fsm: RTL and testbench
===================================

Name: camera_frame_fsm

Overview:
- Downstream consumer of the exposure-time register output `EX_time`.
- On an `Init` request it runs one full frame on the pixel array: erase release, exposure for `EX_time` clock cycles, then row-by-row readout with ADC strobes.
- Drives the pixel-array control lines and the ADC conversion strobe.
- Reports `Busy` to the top-level controller.

Parameters:
- EXP_WIDTH, 5, width of `EX_time` input and of the internal exposure counter.
- EXP_MIN, 2, lowest exposure length in cycles; smaller `EX_time` values are clamped up to it.
- EXP_MAX, 30, highest exposure length in cycles; larger `EX_time` values are clamped down to it.
- ROWS, 2, number of pixel rows read out per frame.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- Init  input  1  frame start request, level-sampled only in IDLE.
- EX_time  input  EXP_WIDTH  requested exposure length in Clk cycles.
- Erase  output  1  pixel erase; high holds pixels erased.
- Expose  output  1  pixel exposure enable, high during exposure.
- NRE  output  ROWS  active-low row read enables; bit i selects row i.
- ADC  output  1  one-cycle ADC conversion strobe.
- Busy  output  1  high whenever a frame is in progress.

Behaviour:
- All outputs registered, with no combinational path from input to output.
- Reset (Reset=0 at a rising edge): state=IDLE, Erase=1, Expose=0, NRE=all 1, ADC=0, Busy=0, counters=0.
  - Reset overrides everything, including a frame in progress; the frame is abandoned with no partial readout.
- States: IDLE, EXPOSE, READOUT.
- IDLE:
  - Outputs: Erase=1, Expose=0, NRE=all 1, ADC=0, Busy=0.
  - If Init=1 at an edge: latch exp = clamp(EX_time, EXP_MIN, EXP_MAX) and go to EXPOSE.
  - At that same edge: Erase<=0, Expose<=1, Busy<=1.
- EXPOSE:
  - Expose stays high for exactly exp cycles, then state goes to READOUT with Expose<=0.
  - EX_time changes during a frame are ignored; only the latched value is used.
- READOUT: rows are read in order 0..ROWS-1, each in a 4-cycle slot (c0..c3):
  - c0: NRE[i]=0.
  - c1: NRE[i]=0, ADC=1.
  - c2: NRE[i]=0, ADC=0.
  - c3: NRE[i]=1.
  - Only one NRE bit is low at a time.
  - After c3 of the last row: state goes to IDLE, with Erase<=1 and Busy<=0.
- Frame length = exp + 4*ROWS cycles of Busy=1. IDLE always lasts at least 1 cycle.
- Init is ignored while Busy=1; no request is queued.
- If Init is held high continuously, frames run back-to-back with exactly 1 IDLE cycle between them.
- Clamp uses an unsigned compare:
  - EX_time=0 or 1 gives exp=2.
  - EX_time=31 gives exp=30.
  - EX_time=30 is used unchanged.
- Invariants:
  - Expose and Erase are never both 1.
  - ADC=1 only while exactly one NRE bit is 0.

Test Plan:
- Reset then EX_time=10, Init pulsed for 1 cycle (edge 0) -> Expose=1 cycles 1..10; NRE[0]=0 cycles 11..13 with ADC=1 at cycle 12; NRE[1]=0 cycles 15..17 with ADC=1 at cycle 16; Erase=1 and Busy=0 from cycle 19.
- EX_time=0, Init pulse -> Expose high 2 cycles. EX_time=31 -> Expose high 30 cycles. EX_time=2 -> 2 cycles.
- EX_time changed from 10 to 25 at cycle 4 of exposure -> Expose is still high exactly 10 cycles.
- Init pulsed again during EXPOSE and during READOUT -> no effect. Init held high -> Busy shows 1 IDLE cycle between frames, and each frame is identical.
- Reset=0 asserted at exposure cycle 5 -> next edge gives Erase=1, Expose=0, NRE=all 1, Busy=0. Init after release starts a clean frame.
- Every frame checked for invariants: never Expose&&Erase, and ADC only while exactly one NRE bit is low.

Source files
------------

// File: rtl/camera_frame_fsm_if.sv
// Control/status bundle between the top-level controller and the camera
// frame sequencer: frame request and exposure time in, pixel-array/ADC
// control lines and busy status out.
interface camera_frame_fsm_if #(
   parameter int EXP_WIDTH = 5,
   parameter int ROWS      = 2
);
   logic                 Init;
   logic [EXP_WIDTH-1:0] EX_time;
   logic                 Erase;
   logic                 Expose;
   logic [ROWS-1:0]      NRE;
   logic                 ADC;
   logic                 Busy;

   // Controller side: issues requests, observes array control and status.
   modport master (
      output Init,
      output EX_time,
      input  Erase,
      input  Expose,
      input  NRE,
      input  ADC,
      input  Busy
   );

   // Sequencer side: consumes requests, drives array control and status.
   modport slave (
      input  Init,
      input  EX_time,
      output Erase,
      output Expose,
      output NRE,
      output ADC,
      output Busy
   );
endinterface

// File: rtl/camera_frame_fsm.sv
// Camera frame sequencer: on a frame request it releases the pixel erase,
// exposes for a clamped number of cycles, then reads each row out in a
// 4-cycle slot (row enable low for three cycles, ADC strobe in the second).
// Every output comes straight from a flop.
module camera_frame_fsm #(
   parameter int EXP_WIDTH = 5,
   parameter int EXP_MIN   = 2,
   parameter int EXP_MAX   = 30,
   parameter int ROWS      = 2
) (
   input logic               Clk,
   input logic               Reset,
   camera_frame_fsm_if.slave bus
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [EXP_WIDTH-1:0] EXP_MIN_V = EXP_WIDTH'(EXP_MIN);
   localparam logic [EXP_WIDTH-1:0] EXP_MAX_V = EXP_WIDTH'(EXP_MAX);
   localparam logic [EXP_WIDTH-1:0] EXP_ONE   = EXP_WIDTH'(1);
   localparam logic [EXP_WIDTH-1:0] EXP_ZERO  = {EXP_WIDTH{1'b0}};
   localparam logic [ROWS-1:0]      NRE_IDLE  = {ROWS{1'b1}};
   localparam logic [ROWS-1:0]      ROW0_SEL  = ROWS'(1);
   localparam logic [ROW_W-1:0]     ROW_ZERO  = {ROW_W{1'b0}};
   localparam logic [ROW_W-1:0]     ROW_ONE   = ROW_W'(1);
   localparam logic [ROW_W-1:0]     LAST_ROW  = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXPOSE  = 2'd1,
      ST_READOUT = 2'd2
   } state_t;

   state_t               state_q,  state_d;
   logic [EXP_WIDTH-1:0] cnt_q,    cnt_d;     // exposure cycles still to go after the current one
   logic [ROW_W-1:0]     row_q,    row_d;
   logic [1:0]           slot_q,   slot_d;    // position inside the 4-cycle row slot
   logic                 erase_q,  erase_d;
   logic                 expose_q, expose_d;
   logic [ROWS-1:0]      nre_q,    nre_d;
   logic                 adc_q,    adc_d;
   logic                 busy_q,   busy_d;

   // Unsigned clamp of the requested exposure into [EXP_MIN, EXP_MAX].
   function automatic logic [EXP_WIDTH-1:0] clamp_exp(input logic [EXP_WIDTH-1:0] req);
      logic [EXP_WIDTH-1:0] res;
      if (req < EXP_MIN_V) begin
         res = EXP_MIN_V;
      end else if (req > EXP_MAX_V) begin
         res = EXP_MAX_V;
      end else begin
         res = req;
      end
      return res;
   endfunction

   // Active-low row enable vector with only the selected row pulled low.
   function automatic logic [ROWS-1:0] row_lo(input logic [ROW_W-1:0] row);
      return ~(ROW0_SEL << row);
   endfunction

   // Next-state and next-output decode; outputs are computed one cycle ahead
   // so that they can be registered without adding latency to the sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      row_d    = row_q;
      slot_d   = slot_q;
      erase_d  = erase_q;
      expose_d = expose_q;
      nre_d    = nre_q;
      adc_d    = 1'b0;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            row_d  = ROW_ZERO;
            slot_d = 2'd0;
            nre_d  = NRE_IDLE;
            if (bus.Init) begin
               // Latch the clamped exposure; the current cycle counts as the first.
               state_d  = ST_EXPOSE;
               cnt_d    = clamp_exp(bus.EX_time) - EXP_ONE;
               erase_d  = 1'b0;
               expose_d = 1'b1;
               busy_d   = 1'b1;
            end else begin
               state_d  = ST_IDLE;
               cnt_d    = EXP_ZERO;
               erase_d  = 1'b1;
               expose_d = 1'b0;
               busy_d   = 1'b0;
            end
         end

         ST_EXPOSE: begin
            if (cnt_q == EXP_ZERO) begin
               state_d  = ST_READOUT;
               expose_d = 1'b0;
               row_d    = ROW_ZERO;
               slot_d   = 2'd0;
               nre_d    = row_lo(ROW_ZERO);
            end else begin
               cnt_d    = cnt_q - EXP_ONE;
            end
         end

         ST_READOUT: begin
            if (slot_q == 2'd3) begin
               if (row_q == LAST_ROW) begin
                  state_d = ST_IDLE;
                  erase_d = 1'b1;
                  busy_d  = 1'b0;
                  nre_d   = NRE_IDLE;
                  row_d   = ROW_ZERO;
                  slot_d  = 2'd0;
               end else begin
                  row_d   = row_q + ROW_ONE;
                  slot_d  = 2'd0;
                  nre_d   = row_lo(row_q + ROW_ONE);
               end
            end else begin
               slot_d = slot_q + 2'd1;
               // Strobe the ADC in the middle of the row enable window.
               adc_d  = (slot_q == 2'd0);
               if (slot_q == 2'd2) begin
                  nre_d = NRE_IDLE;
               end else begin
                  nre_d = row_lo(row_q);
               end
            end
         end

         default: begin
            state_d  = ST_IDLE;
            cnt_d    = EXP_ZERO;
            row_d    = ROW_ZERO;
            slot_d   = 2'd0;
            erase_d  = 1'b1;
            expose_d = 1'b0;
            nre_d    = NRE_IDLE;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State, counters and output registers; reset abandons any frame in flight.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= EXP_ZERO;
         row_q    <= ROW_ZERO;
         slot_q   <= 2'd0;
         erase_q  <= 1'b1;
         expose_q <= 1'b0;
         nre_q    <= NRE_IDLE;
         adc_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         row_q    <= row_d;
         slot_q   <= slot_d;
         erase_q  <= erase_d;
         expose_q <= expose_d;
         nre_q    <= nre_d;
         adc_q    <= adc_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.Erase  = erase_q;
   assign bus.Expose = expose_q;
   assign bus.NRE    = nre_q;
   assign bus.ADC    = adc_q;
   assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_camera_frame_fsm.sv
// Bench for camera_frame_fsm: a frame-level reference model turns each
// accepted request into the full expected output trace of the frame; the
// per-cycle expectations go into a scoreboard queue that an independent
// monitor drains after every rising edge.
module tb_camera_frame_fsm;

   localparam int EW   = 5;
   localparam int ROWS = 2;
   localparam int VW   = ROWS + 4;

   logic clk;
   logic rst_n;

   camera_frame_fsm_if #(.EXP_WIDTH(EW), .ROWS(ROWS)) bus_if ();

   camera_frame_fsm #(
      .EXP_WIDTH (EW),
      .EXP_MIN   (2),
      .EXP_MAX   (30),
      .ROWS      (ROWS)
   ) dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (bus_if)
   );

   int total = 0;
   int bad   = 0;

   // Expected output vector {Erase, Expose, NRE, ADC, Busy} per cycle.
   logic [VW-1:0] exp_q[$];    // scoreboard: one entry per rising edge
   logic [VW-1:0] plan[$];     // remaining cycles of the frame the model is running

   function automatic logic [VW-1:0] mk(input logic er, input logic ex,
                                        input logic [ROWS-1:0] nre,
                                        input logic adc, input logic busy);
      return {er, ex, nre, adc, busy};
   endfunction

   function automatic logic [VW-1:0] idle_vec();
      logic [ROWS-1:0] ones;
      ones = '1;
      return mk(1'b1, 1'b0, ones, 1'b0, 1'b0);
   endfunction

   // Whole-frame reference: exposure, row slots, then the mandatory idle cycle.
   task automatic build_frame(input int req);
      int e;
      logic [ROWS-1:0] nre;
      e = (req < 2) ? 2 : ((req > 30) ? 30 : req);
      nre = '1;
      for (int i = 0; i < e; i++) plan.push_back(mk(1'b0, 1'b1, nre, 1'b0, 1'b1));
      for (int r = 0; r < ROWS; r++) begin
         for (int s = 0; s < 4; s++) begin
            nre = '1;
            if (s < 3) nre[r] = 1'b0;
            plan.push_back(mk(1'b0, 1'b0, nre, (s == 1), 1'b1));
         end
      end
      plan.push_back(idle_vec());
   endtask

   // Apply inputs for the next rising edge, predict its result, wait a cycle.
   task automatic step(input logic r, input logic init, input logic [EW-1:0] ex);
      rst_n          = r;
      bus_if.Init    = init;
      bus_if.EX_time = ex;
      if (!r) begin
         plan.delete();
         exp_q.push_back(idle_vec());
      end else if (plan.size() == 0) begin
         if (init) begin
            build_frame(int'(ex));
            exp_q.push_back(plan.pop_front());
         end else begin
            exp_q.push_back(idle_vec());
         end
      end else begin
         exp_q.push_back(plan.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic idle_n(input int n, input logic [EW-1:0] ex);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, ex);
   endtask

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: compare DUT outputs against the scoreboard after every edge.
   always @(posedge clk) begin
      logic [VW-1:0] got;
      logic [VW-1:0] want;
      #1;
      got = {bus_if.Erase, bus_if.Expose, bus_if.NRE, bus_if.ADC, bus_if.Busy};
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty t=%0t got=%b want=<none>", $time, got);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            bad++;
            $display("FAIL outputs t=%0t got {Erase,Expose,NRE,ADC,Busy}=%b want=%b",
                     $time, got, want);
         end
      end
      total++;
      if (bus_if.Erase === 1'b1 && bus_if.Expose === 1'b1) begin
         bad++;
         $display("FAIL inv_erase_expose t=%0t got Erase=1 Expose=1 want not both", $time);
      end
      total++;
      if (bus_if.ADC === 1'b1 && $countones(~bus_if.NRE) != 1) begin
         bad++;
         $display("FAIL inv_adc_nre t=%0t got NRE=%b with ADC=1 want exactly one low",
                  $time, bus_if.NRE);
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      step(1'b0, 1'b0, 5'd0);
      step(1'b0, 1'b0, 5'd0);

      // Nominal frame, exposure 10.
      step(1'b1, 1'b1, 5'd10);
      idle_n(22, 5'd10);

      // Clamp boundaries.
      step(1'b1, 1'b1, 5'd0);   idle_n(14, 5'd0);
      step(1'b1, 1'b1, 5'd1);   idle_n(14, 5'd1);
      step(1'b1, 1'b1, 5'd31);  idle_n(42, 5'd31);
      step(1'b1, 1'b1, 5'd30);  idle_n(42, 5'd30);
      step(1'b1, 1'b1, 5'd2);   idle_n(14, 5'd2);

      // EX_time change mid-exposure and Init retriggers while busy.
      step(1'b1, 1'b1, 5'd10);
      idle_n(3, 5'd10);
      step(1'b1, 1'b1, 5'd25);
      idle_n(8, 5'd25);
      step(1'b1, 1'b1, 5'd25);
      idle_n(2, 5'd25);
      step(1'b1, 1'b1, 5'd25);
      idle_n(10, 5'd25);

      // Init held high: back-to-back frames with one idle cycle between.
      for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 5'd7);
      idle_n(20, 5'd7);

      // Reset during exposure, then a clean frame.
      step(1'b1, 1'b1, 5'd12);
      idle_n(4, 5'd12);
      step(1'b0, 1'b0, 5'd12);
      idle_n(2, 5'd12);
      step(1'b1, 1'b1, 5'd4);
      idle_n(16, 5'd4);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic r;
         logic in;
         logic [EW-1:0] ex;
         r  = ($urandom_range(199) != 0);
         in = ($urandom_range(3) == 0);
         ex = EW'($urandom_range(31));
         step(r, in, ex);
      end
      idle_n(45, 5'd0);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d entries want=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
